// File: rtl/kd_tree_seq.sv
// kd_tree_seq: root-side sequencer for the kd_tree node array.
// Walks the root node through rst -> center_fill -> configure_sort_axis -> start_sorting,
// streaming centers out of a 1-cycle-latency RAM, then waits for the tree to report dne.
// Every busy phase has a cycle budget of TMO; running out lands in ERR with the phase recorded.
//
// Ports:
//   clk_i, reset_i        clock and synchronous active-high reset
//   start_i               run request, only honoured while idle/done/err
//   num_centers_i         centers to load (1..MAX_CTR), latched on start
//   sort_axis_i           0=R 1=G 2=B (3 treated as R), latched on start
//   ctr_rd_en_o/addr_o    center RAM read port; ctr_rd_data_i returns one cycle later
//   root_cmd_o/data_o     registered command/data into the root node
//   root_resp_i           response from the root node, compared in the cycle it is seen
//   busy_o/done_o/err_o   run status; err_phase_o names the phase that timed out or failed
//   ctr_sent_o            centers actually driven to the root in the last fill
module kd_tree_seq #(
    parameter int unsigned CMD_W   = 5,
    parameter int unsigned DATA_W  = 24,
    parameter int unsigned MAX_CTR = 16,
    parameter int unsigned TMO     = 1024,
    localparam int unsigned ADDR_W = $clog2(MAX_CTR),
    localparam int unsigned TMO_W  = $clog2(TMO + 1)
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              start_i,
    input  logic [ADDR_W:0]   num_centers_i,
    input  logic [1:0]        sort_axis_i,
    output logic              ctr_rd_en_o,
    output logic [ADDR_W-1:0] ctr_rd_addr_o,
    input  logic [DATA_W-1:0] ctr_rd_data_i,
    output logic [CMD_W-1:0]  root_cmd_o,
    output logic [DATA_W-1:0] root_data_o,
    input  logic [CMD_W-1:0]  root_resp_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_phase_o,
    output logic [ADDR_W:0]   ctr_sent_o
);

    localparam logic [CMD_W-1:0] CmdNop        = CMD_W'(5'h00);
    localparam logic [CMD_W-1:0] CmdRst        = CMD_W'(5'h1f);
    localparam logic [CMD_W-1:0] CmdFill       = CMD_W'(5'h01);
    localparam logic [CMD_W-1:0] CmdAxis       = CMD_W'(5'h02);
    localparam logic [CMD_W-1:0] CmdSort       = CMD_W'(5'h09);
    localparam logic [CMD_W-1:0] RespRstDone   = CMD_W'(5'h1e);
    localparam logic [CMD_W-1:0] RespFillDone  = CMD_W'(5'h05);
    localparam logic [CMD_W-1:0] RespAxisDone  = CMD_W'(5'h07);
    localparam logic [CMD_W-1:0] RespDne       = CMD_W'(5'h10);

    localparam logic [ADDR_W:0]  MaxCtr  = (ADDR_W + 1)'(MAX_CTR);
    localparam logic [ADDR_W:0]  CntOne  = (ADDR_W + 1)'(1);
    localparam logic [TMO_W-1:0] TmoMax  = TMO_W'(TMO);
    localparam logic [TMO_W-1:0] TmoLast = TMO_W'(TMO - 1);

    typedef enum logic [2:0] {StIdle, StRst, StFill, StAxis, StSort, StDone, StErr} state_e;

    state_e              state_q, state_d;
    logic [CMD_W-1:0]    root_cmd_q, root_cmd_d;
    logic [DATA_W-1:0]   root_data_q, root_data_d;
    logic                rd_en_q, rd_en_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                pend_q, pend_d;     // RAM word for a read issued last cycle is on ctr_rd_data_i
    logic [ADDR_W:0]     num_q, num_d;
    logic [ADDR_W:0]     sent_q, sent_d;
    logic [1:0]          axis_q, axis_d;
    logic [1:0]          err_phase_q, err_phase_d;
    logic [TMO_W-1:0]    cnt_q, cnt_d;
    logic                tmo_hit;

    always_comb begin
        state_d     = state_q;
        root_cmd_d  = CmdNop;
        root_data_d = root_data_q;
        rd_en_d     = 1'b0;
        rd_addr_d   = rd_addr_q;
        pend_d      = 1'b0;
        num_d       = num_q;
        sent_d      = sent_q;
        axis_d      = axis_q;
        err_phase_d = err_phase_q;
        // Counter would reach TMO at this edge.
        tmo_hit     = (cnt_q >= TmoLast);

        unique case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    num_d  = num_centers_i;
                    axis_d = (sort_axis_i == 2'd3) ? 2'd0 : sort_axis_i;
                    sent_d = '0;
                    if (num_centers_i == '0 || num_centers_i > MaxCtr) begin
                        state_d     = StErr;
                        err_phase_d = 2'd1;
                    end else begin
                        state_d    = StRst;
                        root_cmd_d = CmdRst;
                    end
                end
            end
            StRst: begin
                if (root_resp_i == RespRstDone) begin
                    state_d   = StFill;
                    rd_en_d   = 1'b1;
                    rd_addr_d = '0;
                end else if (tmo_hit) begin
                    state_d     = StErr;
                    err_phase_d = 2'd0;
                end else begin
                    root_cmd_d = CmdRst;
                end
            end
            StFill: begin
                // Early fill_done wins: outstanding read and registered word are discarded.
                if (root_resp_i == RespFillDone) begin
                    state_d     = StAxis;
                    root_cmd_d  = CmdAxis;
                    root_data_d = DATA_W'(axis_q);
                end else if (tmo_hit) begin
                    state_d     = StErr;
                    err_phase_d = 2'd1;
                end else begin
                    if (rd_en_q) begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                        rd_en_d   = (({1'b0, rd_addr_q} + CntOne) < num_q);
                    end
                    pend_d = rd_en_q;
                    if (pend_q) begin
                        root_cmd_d  = CmdFill;
                        root_data_d = ctr_rd_data_i;
                        sent_d      = sent_q + CntOne;
                    end
                end
            end
            StAxis: begin
                if (root_resp_i == RespAxisDone) begin
                    state_d    = StSort;
                    root_cmd_d = CmdSort;
                end else if (tmo_hit) begin
                    state_d     = StErr;
                    err_phase_d = 2'd2;
                end else begin
                    root_cmd_d  = CmdAxis;
                    root_data_d = DATA_W'(axis_q);
                end
            end
            StSort: begin
                // start_sorting was issued on entry; only dne matters from here.
                if (root_resp_i == RespDne) begin
                    state_d = StDone;
                end else if (tmo_hit) begin
                    state_d     = StErr;
                    err_phase_d = 2'd3;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == TmoMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + TMO_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            root_cmd_q  <= CmdNop;
            root_data_q <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            pend_q      <= 1'b0;
            num_q       <= '0;
            sent_q      <= '0;
            axis_q      <= 2'd0;
            err_phase_q <= 2'd0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            root_cmd_q  <= root_cmd_d;
            root_data_q <= root_data_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            pend_q      <= pend_d;
            num_q       <= num_d;
            sent_q      <= sent_d;
            axis_q      <= axis_d;
            err_phase_q <= err_phase_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ctr_rd_en_o   = rd_en_q;
    assign ctr_rd_addr_o = rd_addr_q;
    assign root_cmd_o    = root_cmd_q;
    assign root_data_o   = root_data_q;
    assign busy_o        = !(state_q == StIdle || state_q == StDone || state_q == StErr);
    assign done_o        = (state_q == StDone);
    assign err_o         = (state_q == StErr);
    assign err_phase_o   = err_phase_q;
    assign ctr_sent_o    = sent_q;

endmodule

// File: tb/tb_kd_tree_seq.sv
// tb_kd_tree_seq: bench for kd_tree_seq.
// A phase-level reference model (phase + cycle-in-phase) predicts every output each cycle;
// a root-node responder answers from the model's view of the run with configurable latencies
// and optional noise codes; directed runs pin the model with hand-derived literals.
module tb_kd_tree_seq;

    localparam int TMO     = 32;
    localparam int MAX_CTR = 16;

    localparam int PH_IDLE = 0, PH_RST = 1, PH_FILL = 2, PH_AXIS = 3;
    localparam int PH_SORT = 4, PH_DONE = 5, PH_ERR = 6;

    localparam logic [4:0] C_NOP = 5'h00, C_RST = 5'h1f, C_FILL = 5'h01;
    localparam logic [4:0] C_AXIS = 5'h02, C_SORT = 5'h09;

    logic        clk = 1'b0;
    logic        reset, start;
    logic [4:0]  num_centers;
    logic [1:0]  sort_axis;
    logic        ctr_rd_en;
    logic [3:0]  ctr_rd_addr;
    logic [23:0] ctr_rd_data;
    logic [4:0]  root_cmd;
    logic [23:0] root_data;
    logic [4:0]  root_resp;
    logic        busy, done, err;
    logic [1:0]  err_phase;
    logic [4:0]  ctr_sent;

    logic [23:0] mem [16];

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 0;

    // Reference model state
    int m_ph, m_cyc, m_num, m_axis, m_sent, m_err_phase;

    kd_tree_seq #(
        .CMD_W   (5),
        .DATA_W  (24),
        .MAX_CTR (MAX_CTR),
        .TMO     (TMO)
    ) dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .start_i       (start),
        .num_centers_i (num_centers),
        .sort_axis_i   (sort_axis),
        .ctr_rd_en_o   (ctr_rd_en),
        .ctr_rd_addr_o (ctr_rd_addr),
        .ctr_rd_data_i (ctr_rd_data),
        .root_cmd_o    (root_cmd),
        .root_data_o   (root_data),
        .root_resp_i   (root_resp),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .err_phase_o   (err_phase),
        .ctr_sent_o    (ctr_sent)
    );

    always #5 clk = ~clk;

    // Center RAM, one cycle read latency
    always @(posedge clk) begin
        if (ctr_rd_en) ctr_rd_data <= mem[ctr_rd_addr];
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int done_code(input int ph);
        case (ph)
            PH_RST:  return 'h1e;
            PH_FILL: return 'h05;
            PH_AXIS: return 'h07;
            PH_SORT: return 'h10;
            default: return -1;
        endcase
    endfunction

    function automatic int fill_sent(input int c, input int num);
        if (c < 1) return 0;
        return (c - 1 > num) ? num : c - 1;
    endfunction

    function automatic logic [4:0] pick_noise(input bit noisy, input int ph);
        logic [4:0] v;
        if (!noisy) return C_NOP;
        do begin
            case ($urandom_range(0, 5))
                0: v = 5'h00;
                1: v = 5'h0a;
                2: v = 5'h1e;
                3: v = 5'h05;
                4: v = 5'h07;
                default: v = 5'h10;
            endcase
        end while (int'(v) == done_code(ph));
        return v;
    endfunction

    // Advance the model by one clock using the inputs that were applied over the last cycle.
    task automatic model_step();
        if (reset) begin
            m_ph = PH_IDLE; m_cyc = 0; m_sent = 0; m_err_phase = 0;
            return;
        end
        case (m_ph)
            PH_IDLE, PH_DONE, PH_ERR: begin
                if (start) begin
                    m_sent = 0;
                    m_cyc  = 0;
                    m_num  = int'(num_centers);
                    m_axis = (sort_axis == 2'd3) ? 0 : int'(sort_axis);
                    if (m_num == 0 || m_num > MAX_CTR) begin
                        m_ph = PH_ERR; m_err_phase = 1;
                    end else begin
                        m_ph = PH_RST;
                    end
                end
            end
            default: begin
                if (m_ph == PH_FILL) m_sent = fill_sent(m_cyc, m_num);
                if (int'(root_resp) == done_code(m_ph)) begin
                    m_ph = m_ph + 1; m_cyc = 0;
                end else if (m_cyc == TMO - 1) begin
                    m_err_phase = m_ph - 1; m_ph = PH_ERR;
                end else begin
                    m_cyc++;
                end
            end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #2;
    endtask

    // Compare process: every output, every cycle, against the model
    always @(negedge clk) begin
        int e_cmd, e_data, e_rd, e_sent;
        bit e_dchk;
        if (chk_en) begin
            e_cmd = int'(C_NOP); e_data = 0; e_dchk = 0;
            case (m_ph)
                PH_RST:  e_cmd = int'(C_RST);
                PH_FILL: if (m_cyc >= 2 && m_cyc - 2 < m_num) begin
                    e_cmd = int'(C_FILL); e_dchk = 1; e_data = int'(mem[m_cyc - 2]);
                end
                PH_AXIS: begin e_cmd = int'(C_AXIS); e_dchk = 1; e_data = m_axis; end
                PH_SORT: e_cmd = (m_cyc == 0) ? int'(C_SORT) : int'(C_NOP);
                default: e_cmd = int'(C_NOP);
            endcase
            e_rd   = (m_ph == PH_FILL && m_cyc < m_num) ? 1 : 0;
            e_sent = (m_ph == PH_FILL) ? fill_sent(m_cyc, m_num) : m_sent;
            chk("root_cmd", int'(root_cmd), e_cmd);
            if (e_dchk) chk("root_data", int'(root_data), e_data);
            chk("ctr_rd_en", int'(ctr_rd_en), e_rd);
            if (e_rd == 1) chk("ctr_rd_addr", int'(ctr_rd_addr), m_cyc);
            chk("busy", int'(busy), (m_ph >= PH_RST && m_ph <= PH_SORT) ? 1 : 0);
            chk("done", int'(done), (m_ph == PH_DONE) ? 1 : 0);
            chk("err", int'(err), (m_ph == PH_ERR) ? 1 : 0);
            chk("err_phase", int'(err_phase), m_err_phase);
            chk("ctr_sent", int'(ctr_sent), e_sent);
        end
    end

    // One run: start, then play the root node until DONE/ERR or a planted reset returns to IDLE.
    // fd_k: fill_done is answered in the cycle the fd_k-th word is visible (-1 = never).
    task automatic run(input int num, input int axis, input int rst_lat, input int fd_k,
                       input int ax_lat, input int dne_lat, input bit noisy,
                       input int busy_start, input int rst_fill,
                       output int beats, output int rst_cyc, output int ax_cyc,
                       output int ax_data, output int bad_beats);
        bit fin;
        int code, fd_cyc;
        beats = 0; rst_cyc = 0; ax_cyc = 0; ax_data = -1; bad_beats = 0; fin = 0;
        fd_cyc = (fd_k < 0) ? -100 : fd_k + 1;
        for (int i = 0; i < 16; i++) mem[i] = 24'($urandom);
        num_centers = 5'(num);
        sort_axis   = 2'(axis);
        root_resp   = C_NOP;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (root_cmd == C_FILL) begin
                if (root_data != mem[beats & 15]) bad_beats++;
                beats++;
            end
            if (root_cmd == C_RST) rst_cyc++;
            if (root_cmd == C_AXIS) begin ax_cyc++; ax_data = int'(root_data); end
            if (m_ph == PH_IDLE || m_ph == PH_DONE || m_ph == PH_ERR) begin
                fin = 1;
                break;
            end
            code = -1;
            case (m_ph)
                PH_RST:  if (m_cyc == rst_lat) code = 'h1e;
                PH_FILL: if (m_cyc == fd_cyc)  code = 'h05;
                PH_AXIS: if (m_cyc == ax_lat)  code = 'h07;
                PH_SORT: if (m_cyc == dne_lat) code = 'h10;
                default: code = -1;
            endcase
            root_resp = (code >= 0) ? 5'(code) : pick_noise(noisy, m_ph);
            start = (busy_start >= 0 && m_ph == PH_RST && m_cyc == busy_start);
            reset = (rst_fill >= 0 && m_ph == PH_FILL && m_cyc == rst_fill);
            tick();
            start = 1'b0;
            reset = 1'b0;
        end
        chk("run_terminates", int'(fin), 1);
    endtask

    initial begin
        int bt, rc, ac, ad, bb;
        int num, fdk, rl, al, dl, bs, rf;
        reset = 1'b1; start = 1'b0; num_centers = '0; sort_axis = '0; root_resp = C_NOP;
        m_ph = PH_IDLE; m_cyc = 0; m_num = 0; m_axis = 0; m_sent = 0; m_err_phase = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        tick();
        chk_en = 1;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_root_cmd", int'(root_cmd), 0);
        chk("reset_root_data", int'(root_data), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_ctr_sent", int'(ctr_sent), 0);

        // T1 happy path
        run(7, 1, 3, 7, 2, 20, 0, -1, -1, bt, rc, ac, ad, bb);
        chk("t1_beats", bt, 7);
        chk("t1_beat_order", bb, 0);
        chk("t1_axis_data", ad, 1);
        chk("t1_rst_cycles", rc, 4);
        chk("t1_axis_cycles", ac, 3);
        chk("t1_done", int'(done), 1);
        chk("t1_ctr_sent", int'(ctr_sent), 7);

        // T6 back-to-back from DONE
        run(5, 2, 1, 5, 0, 0, 1, -1, -1, bt, rc, ac, ad, bb);
        chk("t6_rst_cycles", rc, 2);
        chk("t6_beats", bt, 5);
        chk("t6_axis_data", ad, 2);
        chk("t6_done", int'(done), 1);

        // T2 early fill_done after 4th word
        run(10, 0, 0, 4, 1, 3, 1, -1, -1, bt, rc, ac, ad, bb);
        chk("t2_beats", bt, 4);
        chk("t2_ctr_sent", int'(ctr_sent), 4);
        chk("t2_done", int'(done), 1);

        // T3 axis timeout
        run(3, 2, 2, 3, -1, 5, 1, -1, -1, bt, rc, ac, ad, bb);
        chk("t3_axis_cycles", ac, TMO);
        chk("t3_err", int'(err), 1);
        chk("t3_err_phase", int'(err_phase), 2);
        chk("t3_root_cmd", int'(root_cmd), 0);

        // T4 reset on the 3rd fill beat, then a clean restart
        run(8, 1, 2, -1, 1, 4, 1, -1, 4, bt, rc, ac, ad, bb);
        chk("t4_beats", bt, 3);
        chk("t4_root_cmd", int'(root_cmd), 0);
        chk("t4_busy", int'(busy), 0);
        chk("t4_rd_en", int'(ctr_rd_en), 0);
        run(8, 3, 2, 8, 1, 4, 1, -1, -1, bt, rc, ac, ad, bb);
        chk("t4_restart_done", int'(done), 1);
        chk("t4_restart_sent", int'(ctr_sent), 8);
        chk("t4_axis3_data", ad, 0);

        // T5 start while busy, then illegal counts
        run(5, 0, 3, 5, 1, 2, 1, 1, -1, bt, rc, ac, ad, bb);
        chk("t5_rst_cycles", rc, 4);
        chk("t5_done", int'(done), 1);
        run(0, 0, 3, 5, 1, 2, 1, -1, -1, bt, rc, ac, ad, bb);
        chk("t5_zero_rst", rc, 0);
        chk("t5_zero_err", int'(err), 1);
        chk("t5_zero_phase", int'(err_phase), 1);
        run(17, 0, 3, 5, 1, 2, 1, -1, -1, bt, rc, ac, ad, bb);
        chk("t5_over_err", int'(err), 1);
        chk("t5_over_sent", int'(ctr_sent), 0);

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            num = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 1)) * 17 +
                  int'($urandom_range(0, 1)) * int'($urandom_range(0, 14)) : 1 + int'($urandom_range(0, 15));
            rl  = ($urandom_range(0, 14) == 0) ? -1 : int'($urandom_range(0, 6));
            fdk = ($urandom_range(0, 14) == 0) ? -1 : int'($urandom_range(0, num + 1));
            al  = ($urandom_range(0, 14) == 0) ? -1 : int'($urandom_range(0, 5));
            dl  = ($urandom_range(0, 14) == 0) ? -1 : int'($urandom_range(0, 30));
            bs  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 2)) : -1;
            rf  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 10)) : -1;
            run(num, int'($urandom_range(0, 3)), rl, fdk, al, dl, 1, bs, rf, bt, rc, ac, ad, bb);
            tick();
        end

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
